// File: rtl/uart_rx_axis_fifo.sv
// UART receiver (8N1, or 8E1 with UART_RX_PARITY_EN) feeding a DEPTH-entry FIFO
// that is drained as an AXI-Stream master; tlast marks bytes equal to LAST_CHAR.
module uart_rx_axis_fifo #(
    parameter int              WIDTH     = 8,
    parameter int              DEPTH     = 8,
    parameter int              CLK_RATE  = 50000000,
    parameter int              BAUD      = 115200,
    parameter logic [WIDTH-1:0] LAST_CHAR = 'h0A
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       rx,
    output logic [WIDTH-1:0]           m_axis_data,
    output logic                       m_axis_valid,
    input  logic                       m_axis_ready,
    output logic                       m_axis_last,
    output logic                       frame_err,
    output logic                       overrun,
`ifdef UART_RX_PARITY_EN
    output logic                       parity_err,
`endif
    output logic [$clog2(DEPTH+1)-1:0] fifo_count
);

    localparam int CLKS_PER_BIT = CLK_RATE / BAUD;
    localparam int HALF_BIT     = CLKS_PER_BIT / 2;
    localparam int PW           = $clog2(DEPTH);
    localparam int CW           = $clog2(DEPTH + 1);
    localparam int BCW          = $clog2(CLKS_PER_BIT + 1);
    localparam int IW           = $clog2(WIDTH + 1);

    localparam logic [BCW-1:0] HALF_LAST = BCW'(HALF_BIT - 1);
    localparam logic [BCW-1:0] BIT_LAST  = BCW'(CLKS_PER_BIT - 1);
    localparam logic [IW-1:0]  IDX_LAST  = IW'(WIDTH - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
`ifdef UART_RX_PARITY_EN
        S_PARITY,
`endif
        S_STOP,
        S_WAIT_IDLE
    } state_t;

    logic             rx_meta_reg;
    logic             rx_s;
    state_t           state_reg;
    logic [BCW-1:0]   baud_cnt_reg;
    logic [IW-1:0]    bit_idx_reg;
    logic [WIDTH-1:0] shift_reg;
    logic             frame_err_reg;
    logic             push_stb;
    logic             bit_tick;
`ifdef UART_RX_PARITY_EN
    logic             parity_bad_reg;
    logic             parity_err_reg;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_meta_reg <= 1'b1;
            rx_s        <= 1'b1;
        end else begin
            rx_meta_reg <= rx;
            rx_s        <= rx_meta_reg;
        end
    end

    assign bit_tick = (baud_cnt_reg == BIT_LAST);

    // The byte is pushed in the very cycle the stop bit is accepted.
`ifdef UART_RX_PARITY_EN
    assign push_stb = (state_reg == S_STOP) && bit_tick && rx_s && !parity_bad_reg;
`else
    assign push_stb = (state_reg == S_STOP) && bit_tick && rx_s;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg      <= S_IDLE;
            baud_cnt_reg   <= '0;
            bit_idx_reg    <= '0;
            shift_reg      <= '0;
            frame_err_reg  <= 1'b0;
`ifdef UART_RX_PARITY_EN
            parity_bad_reg <= 1'b0;
            parity_err_reg <= 1'b0;
`endif
        end else begin
            frame_err_reg  <= 1'b0;
`ifdef UART_RX_PARITY_EN
            parity_err_reg <= 1'b0;
`endif
            case (state_reg)
                S_IDLE: begin
                    baud_cnt_reg <= '0;
                    if (!rx_s) state_reg <= S_START;
                end
                S_START: begin
                    if (baud_cnt_reg == HALF_LAST) begin
                        baud_cnt_reg <= '0;
                        bit_idx_reg  <= '0;
                        state_reg    <= rx_s ? S_IDLE : S_DATA;
                    end else begin
                        baud_cnt_reg <= baud_cnt_reg + 1'b1;
                    end
                end
                S_DATA: begin
                    if (bit_tick) begin
                        baud_cnt_reg <= '0;
                        shift_reg    <= {rx_s, shift_reg[WIDTH-1:1]};
                        if (bit_idx_reg == IDX_LAST) begin
`ifdef UART_RX_PARITY_EN
                            state_reg <= S_PARITY;
`else
                            state_reg <= S_STOP;
`endif
                        end else begin
                            bit_idx_reg <= bit_idx_reg + 1'b1;
                        end
                    end else begin
                        baud_cnt_reg <= baud_cnt_reg + 1'b1;
                    end
                end
`ifdef UART_RX_PARITY_EN
                S_PARITY: begin
                    if (bit_tick) begin
                        baud_cnt_reg   <= '0;
                        parity_bad_reg <= ^{shift_reg, rx_s};
                        state_reg      <= S_STOP;
                    end else begin
                        baud_cnt_reg <= baud_cnt_reg + 1'b1;
                    end
                end
`endif
                S_STOP: begin
                    if (bit_tick) begin
                        baud_cnt_reg <= '0;
                        if (!rx_s) begin
                            // Frame error wins over parity; wait out any break.
                            frame_err_reg <= 1'b1;
                            state_reg     <= S_WAIT_IDLE;
                        end else begin
`ifdef UART_RX_PARITY_EN
                            parity_err_reg <= parity_bad_reg;
`endif
                            state_reg <= S_IDLE;
                        end
                    end else begin
                        baud_cnt_reg <= baud_cnt_reg + 1'b1;
                    end
                end
                S_WAIT_IDLE: begin
                    if (rx_s) state_reg <= S_IDLE;
                end
                default: state_reg <= S_IDLE;
            endcase
        end
    end

    assign frame_err = frame_err_reg;
`ifdef UART_RX_PARITY_EN
    assign parity_err = parity_err_reg;
`endif

    logic [WIDTH:0]  mem [DEPTH];
    logic [PW-1:0]   wr_ptr_reg;
    logic [PW-1:0]   rd_ptr_reg;
    logic [CW-1:0]   count_reg;
    logic            overrun_reg;
    logic            pop;
    logic            wr_en;
    logic [WIDTH:0]  head;

    assign pop   = m_axis_valid && m_axis_ready;
    assign wr_en = push_stb && ((count_reg < CW'(DEPTH)) || pop);

    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr_reg] <= {shift_reg == LAST_CHAR, shift_reg};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_reg  <= '0;
            rd_ptr_reg  <= '0;
            count_reg   <= '0;
            overrun_reg <= 1'b0;
        end else begin
            overrun_reg <= push_stb && !wr_en;
            if (wr_en) wr_ptr_reg <= wr_ptr_reg + 1'b1;
            if (pop)   rd_ptr_reg <= rd_ptr_reg + 1'b1;
            case ({wr_en, pop})
                2'b10:   count_reg <= count_reg + 1'b1;
                2'b01:   count_reg <= count_reg - 1'b1;
                default: count_reg <= count_reg;
            endcase
        end
    end

    // Gate the head so outputs read 0 while the FIFO is empty.
    assign head         = mem[rd_ptr_reg];
    assign m_axis_valid = (count_reg != '0);
    assign m_axis_data  = m_axis_valid ? head[WIDTH-1:0] : '0;
    assign m_axis_last  = m_axis_valid ? head[WIDTH] : 1'b0;
    assign overrun      = overrun_reg;
    assign fifo_count   = count_reg;

endmodule

// File: tb/tb_uart_rx_axis_fifo.sv
// Self-checking bench for uart_rx_axis_fifo: directed scenarios plus a randomized
// byte stream compared against a queue-based model of the receive FIFO.
module tb_uart_rx_axis_fifo;

    localparam int WIDTH    = 8;
    localparam int DEPTH    = 8;
    localparam int CLK_RATE = 3200000;
    localparam int BAUD     = 100000;
    localparam int CPB      = CLK_RATE / BAUD;
    localparam logic [7:0] LAST_CHAR = 8'h0A;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rx  = 1'b1;
    logic       m_axis_ready = 1'b0;
    logic [7:0] m_axis_data;
    logic       m_axis_valid;
    logic       m_axis_last;
    logic       frame_err;
    logic       overrun;
    logic [3:0] fifo_count;
`ifdef UART_RX_PARITY_EN
    logic       parity_err;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    uart_rx_axis_fifo #(
        .WIDTH(WIDTH), .DEPTH(DEPTH), .CLK_RATE(CLK_RATE), .BAUD(BAUD), .LAST_CHAR(LAST_CHAR)
    ) dut (
        .clk(clk),
        .rst(rst),
        .rx(rx),
        .m_axis_data(m_axis_data),
        .m_axis_valid(m_axis_valid),
        .m_axis_ready(m_axis_ready),
        .m_axis_last(m_axis_last),
        .frame_err(frame_err),
        .overrun(overrun),
`ifdef UART_RX_PARITY_EN
        .parity_err(parity_err),
`endif
        .fifo_count(fifo_count)
    );

    // Observer: records every AXIS handshake and counts pulses, sampled mid-cycle.
    int         cyc = 0;
    logic [8:0] pop_q[$];
    int         pop_cyc_q[$];
    int         fe_cnt = 0;
    int         ov_cnt = 0;
    int         valid_cnt = 0;

    always @(negedge clk) begin
        cyc = cyc + 1;
        if (m_axis_valid && m_axis_ready) begin
            pop_q.push_back({m_axis_last, m_axis_data});
            pop_cyc_q.push_back(cyc);
        end
        if (frame_err)    fe_cnt = fe_cnt + 1;
        if (overrun)      ov_cnt = ov_cnt + 1;
        if (m_axis_valid) valid_cnt = valid_cnt + 1;
    end

    // Model of FIFO contents while the consumer is stalled.
    logic [8:0] model_q[$];
    int         model_ov = 0;

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop_bit);
        rx = 1'b0;
        step(CPB);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            step(CPB);
        end
        rx = stop_bit;
        step(CPB);
    endtask

    task automatic send_modeled(input logic [7:0] b);
        send_frame(b, 1'b1);
        if (model_q.size() < DEPTH) model_q.push_back({b == LAST_CHAR, b});
        else model_ov++;
    endtask

    function automatic logic [8:0] pop_at(input int idx);
        if (idx < pop_q.size()) return pop_q[idx];
        return 9'bx;
    endfunction

    task automatic test_reset();
        int v0;
        rst = 1'b1;
        rx = 1'b1;
        m_axis_ready = 1'b0;
        step(4);
        checks++; if (m_axis_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %0b want 0", m_axis_valid); end
        checks++; if (m_axis_data !== 8'h00) begin errors++; $display("FAIL reset_data got %02h want 00", m_axis_data); end
        checks++; if (m_axis_last !== 1'b0) begin errors++; $display("FAIL reset_last got %0b want 0", m_axis_last); end
        checks++; if (frame_err !== 1'b0) begin errors++; $display("FAIL reset_frame_err got %0b want 0", frame_err); end
        checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL reset_overrun got %0b want 0", overrun); end
        checks++; if (fifo_count !== 4'd0) begin errors++; $display("FAIL reset_count got %0d want 0", fifo_count); end
        rst = 1'b0;
        v0 = valid_cnt;
        step(1000);
        checks++; if (valid_cnt - v0 !== 0) begin errors++; $display("FAIL idle_valid got %0d valid cycles want 0", valid_cnt - v0); end
        $display("test_reset done");
    endtask

    task automatic test_single_byte();
        int p0, v0, f0, o0;
        m_axis_ready = 1'b1;
        p0 = pop_q.size(); v0 = valid_cnt; f0 = fe_cnt; o0 = ov_cnt;
        send_frame(8'h55, 1'b1);
        step(20);
        checks++; if (pop_q.size() - p0 !== 1) begin errors++; $display("FAIL single_pops got %0d want 1", pop_q.size() - p0); end
        checks++; if (pop_at(p0) !== {1'b0, 8'h55}) begin errors++; $display("FAIL single_data got %03h want 055", pop_at(p0)); end
        checks++; if (valid_cnt - v0 !== 1) begin errors++; $display("FAIL single_valid_width got %0d want 1", valid_cnt - v0); end
        checks++; if (fe_cnt - f0 !== 0) begin errors++; $display("FAIL single_frame_err got %0d want 0", fe_cnt - f0); end
        checks++; if (ov_cnt - o0 !== 0) begin errors++; $display("FAIL single_overrun got %0d want 0", ov_cnt - o0); end
        $display("test_single_byte rx 55 -> popped %03h", pop_at(p0));
    endtask

    task automatic test_burst_last();
        int p0, n;
        logic [8:0] exp_q[$];
        m_axis_ready = 1'b0;
        model_q.delete();
        send_modeled(8'h48);
        send_modeled(8'h69);
        send_modeled(8'h0A);
        exp_q = model_q;
        step(5);
        checks++; if (fifo_count !== 4'(model_q.size())) begin errors++; $display("FAIL burst_count got %0d want %0d", fifo_count, model_q.size()); end
        for (int i = 0; i < 16; i++) begin
            checks++;
            if ({m_axis_valid, m_axis_last, m_axis_data} !== {1'b1, exp_q[0]}) begin
                errors++; $display("FAIL burst_hold cycle %0d got v%0b %03h want v1 %03h", i, m_axis_valid, {m_axis_last, m_axis_data}, exp_q[0]);
            end
            step(1);
        end
        p0 = pop_q.size();
        m_axis_ready = 1'b1;
        step(DEPTH + 4);
        m_axis_ready = 1'b0;
        n = pop_q.size() - p0;
        checks++; if (n !== 3) begin errors++; $display("FAIL burst_pops got %0d want 3", n); end
        for (int i = 0; i < 3; i++) begin
            checks++; if (pop_at(p0 + i) !== exp_q[i]) begin errors++; $display("FAIL burst_data[%0d] got %03h want %03h", i, pop_at(p0 + i), exp_q[i]); end
            $display("test_burst_last pop %0d -> %03h", i, pop_at(p0 + i));
        end
        if (n == 3) begin
            checks++;
            if (pop_cyc_q[p0 + 2] - pop_cyc_q[p0] !== 2) begin errors++; $display("FAIL burst_back_to_back got span %0d want 2", pop_cyc_q[p0 + 2] - pop_cyc_q[p0]); end
        end
        checks++; if (fifo_count !== 4'd0) begin errors++; $display("FAIL burst_final_count got %0d want 0", fifo_count); end
    endtask

    task automatic test_overrun();
        int p0, o0;
        logic [8:0] exp_q[$];
        m_axis_ready = 1'b0;
        model_q.delete();
        model_ov = 0;
        o0 = ov_cnt;
        for (int i = 1; i <= 9; i++) send_modeled(8'(i));
        exp_q = model_q;
        step(5);
        checks++; if (ov_cnt - o0 !== model_ov) begin errors++; $display("FAIL overrun_pulses got %0d want %0d", ov_cnt - o0, model_ov); end
        checks++; if (fifo_count !== 4'(model_q.size())) begin errors++; $display("FAIL overrun_count got %0d want %0d", fifo_count, model_q.size()); end
        p0 = pop_q.size();
        m_axis_ready = 1'b1;
        step(DEPTH + 4);
        m_axis_ready = 1'b0;
        checks++; if (pop_q.size() - p0 !== exp_q.size()) begin errors++; $display("FAIL overrun_pops got %0d want %0d", pop_q.size() - p0, exp_q.size()); end
        foreach (exp_q[i]) begin
            checks++; if (pop_at(p0 + i) !== exp_q[i]) begin errors++; $display("FAIL overrun_data[%0d] got %03h want %03h", i, pop_at(p0 + i), exp_q[i]); end
        end
        checks++; if (fifo_count !== 4'd0) begin errors++; $display("FAIL overrun_final_count got %0d want 0", fifo_count); end
        $display("test_overrun sent 9, overruns %0d, drained %0d", ov_cnt - o0, pop_q.size() - p0);
    endtask

    task automatic test_frame_error();
        int p0, f0;
        m_axis_ready = 1'b1;
        p0 = pop_q.size(); f0 = fe_cnt;
        send_frame(8'hA5, 1'b0);
        step(3 * CPB);
        checks++; if (fe_cnt - f0 !== 1) begin errors++; $display("FAIL frame_err_pulse got %0d want 1", fe_cnt - f0); end
        rx = 1'b1;
        step(3 * CPB);
        checks++; if (fe_cnt - f0 !== 1) begin errors++; $display("FAIL frame_err_break got %0d pulses want 1", fe_cnt - f0); end
        checks++; if (pop_q.size() - p0 !== 0) begin errors++; $display("FAIL frame_err_push got %0d pops want 0", pop_q.size() - p0); end
        send_frame(8'h3C, 1'b1);
        step(20);
        checks++; if (pop_q.size() - p0 !== 1) begin errors++; $display("FAIL recover_pops got %0d want 1", pop_q.size() - p0); end
        checks++; if (pop_at(p0) !== {1'b0, 8'h3C}) begin errors++; $display("FAIL recover_data got %03h want 03c", pop_at(p0)); end
        $display("test_frame_error frame_err %0d, then rx 3C -> %03h", fe_cnt - f0, pop_at(p0));
    endtask

    task automatic test_glitch_and_reset();
        int p0, f0;
        logic [7:0] partial;
        partial = 8'h77;
        m_axis_ready = 1'b1;
        p0 = pop_q.size(); f0 = fe_cnt;
        rx = 1'b0;
        step(CPB / 4);
        rx = 1'b1;
        step(12 * CPB);
        checks++; if (pop_q.size() - p0 !== 0) begin errors++; $display("FAIL glitch_push got %0d pops want 0", pop_q.size() - p0); end
        checks++; if (fe_cnt - f0 !== 0) begin errors++; $display("FAIL glitch_frame_err got %0d want 0", fe_cnt - f0); end
        m_axis_ready = 1'b0;
        send_frame(8'h99, 1'b1);
        step(4);
        checks++; if (fifo_count !== 4'd1) begin errors++; $display("FAIL pre_reset_count got %0d want 1", fifo_count); end
        rx = 1'b0;
        step(CPB);
        for (int i = 0; i < 3; i++) begin
            rx = partial[i];
            step(CPB);
        end
        rst = 1'b1;
        step(2);
        rx = 1'b1;
        checks++; if (fifo_count !== 4'd0) begin errors++; $display("FAIL mid_reset_count got %0d want 0", fifo_count); end
        checks++; if (m_axis_valid !== 1'b0) begin errors++; $display("FAIL mid_reset_valid got %0b want 0", m_axis_valid); end
        step(2);
        rst = 1'b0;
        step(2 * CPB);
        checks++; if (fifo_count !== 4'd0) begin errors++; $display("FAIL post_reset_count got %0d want 0", fifo_count); end
        m_axis_ready = 1'b1;
        p0 = pop_q.size();
        send_frame(8'h12, 1'b1);
        step(20);
        checks++; if (pop_q.size() - p0 !== 1) begin errors++; $display("FAIL post_reset_pops got %0d want 1", pop_q.size() - p0); end
        checks++; if (pop_at(p0) !== {1'b0, 8'h12}) begin errors++; $display("FAIL post_reset_data got %03h want 012", pop_at(p0)); end
        $display("test_glitch_and_reset rx 12 after reset -> %03h", pop_at(p0));
    endtask

    task automatic test_random_stream();
        int p0, f0, o0;
        logic [8:0] exp_q[$];
        bit done;
        done = 1'b0;
        p0 = pop_q.size(); f0 = fe_cnt; o0 = ov_cnt;
        fork
            begin
                for (int n = 0; n < 12; n++) begin
                    logic [7:0] b;
                    b = 8'($urandom);
                    if ($urandom_range(0, 3) == 0) b = LAST_CHAR;
                    exp_q.push_back({b == LAST_CHAR, b});
                    send_frame(b, 1'b1);
                    step($urandom_range(0, CPB));
                end
                done = 1'b1;
            end
            begin
                while (!done) begin
                    m_axis_ready = 1'($urandom_range(0, 1));
                    step(1);
                end
                m_axis_ready = 1'b1;
            end
        join
        step(4 * DEPTH);
        checks++; if (pop_q.size() - p0 !== exp_q.size()) begin errors++; $display("FAIL random_pops got %0d want %0d", pop_q.size() - p0, exp_q.size()); end
        foreach (exp_q[i]) begin
            checks++; if (pop_at(p0 + i) !== exp_q[i]) begin errors++; $display("FAIL random_data[%0d] got %03h want %03h", i, pop_at(p0 + i), exp_q[i]); end
            $display("test_random_stream byte %0d sent %02h -> popped %03h", i, exp_q[i][7:0], pop_at(p0 + i));
        end
        checks++; if (ov_cnt - o0 !== 0) begin errors++; $display("FAIL random_overrun got %0d want 0", ov_cnt - o0); end
        checks++; if (fe_cnt - f0 !== 0) begin errors++; $display("FAIL random_frame_err got %0d want 0", fe_cnt - f0); end
        checks++; if (fifo_count !== 4'd0) begin errors++; $display("FAIL random_final_count got %0d want 0", fifo_count); end
    endtask

    initial begin
        test_reset();
        test_single_byte();
        test_burst_last();
        test_overrun();
        test_frame_error();
        test_glitch_and_reset();
        test_random_stream();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_rx_axis_fifo.md
Name: uart_rx_axis_fifo

Overview:
UART-to-AXI-Stream receive path, the counterpart of the AXIS-to-UART transmit path (axis_fifo_uart_tx).
- Deserialises 8N1 frames from the serial line.
- Buffers received bytes in a DEPTH-entry FIFO.
- Presents them as an AXI-Stream master, with tlast derived from a configurable end-of-frame character.
- Sits between the board RX pin and the downstream AXIS consumer.

Parameters:
WIDTH, 8, data bits per UART frame and AXIS data width
DEPTH, 8, FIFO entries; power of two, >=2
CLK_RATE, 50000000, clk frequency in Hz
BAUD, 115200, line rate; CLKS_PER_BIT = CLK_RATE/BAUD (integer division, 434 at defaults)
LAST_CHAR, 8'h0A, received byte value that is tagged m_axis_last=1

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  asynchronous, active-high reset
rx  input  1  serial line, idle high, asynchronous to clk
m_axis_data  output  WIDTH  head-of-FIFO byte
m_axis_valid  output  1  FIFO non-empty
m_axis_ready  input  1  downstream accept
m_axis_last  output  1  head byte == LAST_CHAR
frame_err  output  1  one-cycle pulse: stop bit sampled low
overrun  output  1  one-cycle pulse: byte dropped because FIFO full
fifo_count  output  clog2(DEPTH+1)  current occupancy

Behaviour:
Reset:
- All outputs 0; fifo_count 0.
- The two rx synchroniser flops reset to 1 (idle).
- FSM goes to IDLE; pointers and baud/bit counters cleared.
- Reset asserted mid-frame or mid-transfer discards the partial byte and all FIFO contents.

RX input:
- rx passes through a 2-flop synchroniser (rx_s); all decisions use rx_s.

FSM states: IDLE, START, DATA, (PARITY), STOP, WAIT_IDLE.
- IDLE: rx_s==0 -> START, baud counter cleared.
- START: after CLKS_PER_BIT/2 clocks, resample rx_s.
  - 0 -> DATA, bit index 0.
  - 1 -> IDLE (glitch rejected, nothing pushed).
- DATA: sample every CLKS_PER_BIT clocks, LSB first into a shift register; after WIDTH samples -> STOP (or PARITY when the optional feature is enabled).
- STOP: sample after CLKS_PER_BIT.
  - 1 -> push byte, then IDLE.
  - 0 -> frame_err pulse, no push, go to WAIT_IDLE.
- WAIT_IDLE: stay until rx_s==1, then IDLE. Break conditions are not re-detected as start bits.

Push:
- Single-cycle write strobe in the cycle the stop bit is accepted.
- Stored entry = {byte==LAST_CHAR, byte}.
- Push is accepted if fifo_count<DEPTH, or if a pop occurs in the same cycle.
- Otherwise the byte is dropped and overrun pulses for 1 cycle; FIFO contents are unchanged.

Pop / AXIS master:
- m_axis_valid = (fifo_count!=0).
- m_axis_data and m_axis_last are driven from the head entry.
- Pop occurs when m_axis_valid && m_axis_ready.
- While valid && !ready, data and last hold stable and valid never deasserts.
- First byte appears on m_axis_valid 1 cycle after its push strobe.

Count and pointers:
- Push-only: count +1; pop-only: count -1; simultaneous push and pop: count unchanged.
- Pointers are clog2(DEPTH) bits and wrap naturally.
- Pop on empty is impossible (gated by valid); push on full follows the overrun rule above.

Latency:
- Falling edge of the start bit to push ≈ 2 (sync) + (WIDTH+1.5)*CLKS_PER_BIT clocks.

Optional Feature:
UART_RX_PARITY_EN
- Defined:
  - Frame is 8E1; PARITY state samples one extra bit after DATA.
  - Even parity is checked over data plus parity bit.
  - On mismatch, the byte is discarded (no push) and output parity_err (1 bit, reset 0) pulses for 1 cycle in the STOP-accept cycle.
  - If the stop bit is also low, frame_err takes precedence and parity_err does not pulse.
- Undefined:
  - 8N1 as above; the PARITY state and the parity_err port do not exist.

Test Plan:
- Reset, rx idle high -> all outputs 0, fifo_count 0; after release, m_axis_valid stays 0 for 1000 clocks.
- Send 0x55 at 434 clks/bit, m_axis_ready=1 -> m_axis_valid pulses 1 cycle with data 0x55, last 0; frame_err and overrun stay 0.
- Send 0x48,0x69,0x0A with m_axis_ready=0 -> fifo_count 3.
  - Then ready=1 pops 0x48 (last0), 0x69 (last0), 0x0A (last1) on consecutive cycles; count returns to 0.
- Send 9 bytes 0x01..0x09 with ready=0 (DEPTH 8) -> 9th byte gives overrun pulse; count 8; readout 0x01..0x08.
- Send 0xA5 with stop bit driven low, then line held low for 3 bit times -> frame_err pulse, no push, no spurious start until rx returns high.
  - Next byte 0x3C is received correctly.
- 200-clock low glitch on idle rx -> rejected in START, no push; assert rst mid-DATA of 0x77 -> FIFO empty, FSM IDLE, next full frame 0x12 received.
